seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 25 ++
 rtl/seg_decoder.sv | 11 +
 rtl/seg_scan_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller:
// FSM encoding, hex-to-segment table and segment bit positions.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam int SEG_DP_BIT = 0;
  localparam int SEG_G_BIT  = 1;
  localparam int SEG_A_BIT  = 7;

  // Segments a..g in bits 7..1, bit 0 left clear for the decimal point.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h9E, 8'h7A, 8'h1A, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  function automatic logic [7:0] seg_lookup(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to 7-segment pattern; purely combinational, dp bit always 0.
module seg_decoder
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  assign seg = seg_lookup(hex);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed hex display scanner: BLANK/SHOW slot per digit, double-
// buffered value committed only at the frame wrap, optional leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NDIG  = 8,
  parameter int SLOT  = 1000,
  parameter int BLANK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp,
  input  logic              lz_sup,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   dig_n,
  output logic              frame_done
);

  localparam int CW = $clog2(SLOT);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SLOT - BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*NDIG-1:0]   act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NDIG-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                pend_vld_q, pend_vld_d;
  logic [7:0]          seg_q, seg_d;
  logic [NDIG-1:0]     dig_n_q, dig_n_d;
  logic                wrap;
  logic [NDIG-1:0]     nz_from;
  logic                nz_acc;
  logic [3:0]          cur_hex;
  logic [7:0]          dec_seg;

  assign wrap = en && (state_q == ST_SHOW) && (cnt_q == SHOW_LAST) && (idx_q == IDX_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;

    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp;
      pend_vld_d = 1'b1;
    end

    if (!en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    // A load landing on the wrap edge bypasses pending so it is not lost a frame.
    if (wrap) begin
      if (load) begin
        act_val_d  = value;
        act_dp_d   = dp;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        act_val_d  = pend_val_q;
        act_dp_d   = pend_dp_q;
        pend_vld_d = 1'b0;
      end
    end
  end

  // Outputs are decoded from next-state values so they switch on the same edge.
  assign cur_hex = act_val_d[4*int'(idx_d) +: 4];

  seg_decoder u_dec (
    .hex (cur_hex),
    .seg (dec_seg)
  );

  always_comb begin
    nz_from = '0;
    nz_acc  = 1'b0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      nz_acc     = nz_acc | (|act_val_d[4*k +: 4]);
      nz_from[k] = nz_acc;
    end
  end

  always_comb begin
    seg_d   = '0;
    dig_n_d = '1;
    if (state_d == ST_SHOW) begin
      dig_n_d[idx_d] = 1'b0;
      seg_d[SEG_A_BIT:SEG_G_BIT] = dec_seg[SEG_A_BIT:SEG_G_BIT];
      if (lz_sup && (idx_d != '0) && !nz_from[idx_d])
        seg_d[SEG_A_BIT:SEG_G_BIT] = '0;
      seg_d[SEG_DP_BIT] = act_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      idx_q      <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= '0;
      dig_n_q    <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dig_n_q    <= dig_n_d;
    end
  end

  assign seg        = seg_q;
  assign dig_n      = dig_n_q;
  assign frame_done = wrap;

endmodule
